// File: rtl/sobel_edge_threshold_pkg.sv
// Shared video constants and types for the Sobel edge-threshold pipeline.
// Edge pixels are white, active non-edge pixels black, blanking is all zero.
package sobel_edge_threshold_pkg;
    localparam int GRAD_W = 8;
    localparam int PIX_W  = 24;

    localparam logic [PIX_W-1:0] YCBCR_WHITE = 24'hFF8080;
    localparam logic [PIX_W-1:0] YCBCR_BLACK = 24'h008080;
    localparam logic [PIX_W-1:0] YCBCR_BLANK = 24'h000000;

    typedef struct packed {
        logic de;
        logic h_sync;
        logic v_sync;
    } sync_t;
endpackage

// File: rtl/sobel_edge_threshold_if.sv
// Video-in / edge-out bundle for sobel_edge_threshold; master is the source
// of gradients and threshold, slave is the edge detector.
interface sobel_edge_threshold_if #(
    parameter int CNT_W = 21
);
    import sobel_edge_threshold_pkg::*;

    logic [PIX_W-1:0] pixel_gx_in;
    logic [PIX_W-1:0] pixel_gy_in;
    logic             de_in;
    logic             h_sync_in;
    logic             v_sync_in;
    logic [7:0]       threshold;

    logic [PIX_W-1:0] pixel_out;
    logic             de_out;
    logic             h_sync_out;
    logic             v_sync_out;
    logic [CNT_W-1:0] edge_count;
    logic             count_valid;

    modport master (
        output pixel_gx_in, pixel_gy_in, de_in, h_sync_in, v_sync_in, threshold,
        input  pixel_out, de_out, h_sync_out, v_sync_out, edge_count, count_valid
    );

    modport slave (
        input  pixel_gx_in, pixel_gy_in, de_in, h_sync_in, v_sync_in, threshold,
        output pixel_out, de_out, h_sync_out, v_sync_out, edge_count, count_valid
    );
endinterface

// File: rtl/sobel_edge_threshold_sync_pipe.sv
// Resettable shift register carrying {de, h_sync, v_sync} alongside the
// datapath; every tap is exposed so later stages can use the aligned de.
module sync_pipe #(
    parameter int W      = 3,
    parameter int STAGES = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [W-1:0]                 din,
    output logic [STAGES-1:0][W-1:0]     taps
);
    always_ff @(posedge clk) begin
        if (rst) begin
            taps <= '0;
        end else begin
            taps[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end
endmodule

// File: rtl/sobel_edge_threshold.sv
// Three-stage Sobel magnitude threshold: |Gx|,|Gy| -> sum -> binary pixel,
// plus a per-frame saturating edge counter published on v_sync_out rise.
module sobel_edge_threshold
    import sobel_edge_threshold_pkg::*;
#(
    parameter logic [7:0] THRESH_INIT = 8'd64,
    parameter int         CNT_W       = 21
) (
    input  logic                  clk,
    input  logic                  rst,
    sobel_edge_threshold_if.slave vif
);
    localparam int STAGES = 3;
    localparam int SYNC_W = $bits(sync_t);

    // -128 has no positive 8-bit signed image, but fits as unsigned 128
    function automatic logic [GRAD_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
        logic [GRAD_W-1:0] u;
        u = g;
        return g[GRAD_W-1] ? (~u + GRAD_W'(1)) : u;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        if (en && (c != {CNT_W{1'b1}})) begin
            return c + CNT_W'(1);
        end
        return c;
    endfunction

    logic signed [GRAD_W-1:0]     gx_p0, gy_p0;
    sync_t                        sync_p0, sync_p2, sync_p3;
    logic [STAGES-1:0][SYNC_W-1:0] sync_taps;

    logic [GRAD_W-1:0] abs_gx_p1, abs_gy_p1;
    logic [15:0]       cbcr_p1, cbcr_p2;
    logic [GRAD_W:0]   mag_p2;
    logic [PIX_W-1:0]  pixel_p3;
    logic              edge_p3;

    logic              edge_d;
    logic [PIX_W-1:0]  pixel_d;

    logic [7:0]        thr_q;
    logic [CNT_W-1:0]  cnt_q, edge_count_q;
    logic              count_valid_q, vs_prev_q, vs_rise;
    logic              unused_bits;

    assign gx_p0   = vif.pixel_gx_in[23:16];
    assign gy_p0   = vif.pixel_gy_in[23:16];
    assign sync_p0 = '{de: vif.de_in, h_sync: vif.h_sync_in, v_sync: vif.v_sync_in};

    sync_pipe #(
        .W      (SYNC_W),
        .STAGES (STAGES)
    ) u_sync_pipe (
        .clk  (clk),
        .rst  (rst),
        .din  (sync_p0),
        .taps (sync_taps)
    );

    assign sync_p2 = sync_taps[1];
    assign sync_p3 = sync_taps[2];

    // Stage 1: absolute gradients
    always_ff @(posedge clk) begin
        if (rst) begin
            abs_gx_p1 <= '0;
            abs_gy_p1 <= '0;
            cbcr_p1   <= '0;
        end else begin
            abs_gx_p1 <= abs_grad(gx_p0);
            abs_gy_p1 <= abs_grad(gy_p0);
            cbcr_p1   <= vif.pixel_gx_in[15:0];
        end
    end

    // Stage 2: L1 magnitude, 9 bits so 128+128 does not wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            mag_p2  <= '0;
            cbcr_p2 <= '0;
        end else begin
            mag_p2  <= {1'b0, abs_gx_p1} + {1'b0, abs_gy_p1};
            cbcr_p2 <= cbcr_p1;
        end
    end

    // Stage 3: threshold against the frame-latched threshold
    always_comb begin
        edge_d  = sync_p2.de && (mag_p2 > {1'b0, thr_q});
        pixel_d = YCBCR_BLANK;
        if (edge_d) begin
            pixel_d = YCBCR_WHITE;
        end else if (sync_p2.de) begin
            pixel_d = YCBCR_BLACK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_p3 <= '0;
            edge_p3  <= 1'b0;
        end else begin
            pixel_p3 <= pixel_d;
            edge_p3  <= edge_d;
        end
    end

    // An edge on the rising cycle belongs to the frame being closed
    assign vs_rise = sync_p3.v_sync && !vs_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_prev_q     <= 1'b0;
            thr_q         <= THRESH_INIT;
            cnt_q         <= '0;
            edge_count_q  <= '0;
            count_valid_q <= 1'b0;
        end else begin
            vs_prev_q <= sync_p3.v_sync;
            if (vs_rise) begin
                thr_q         <= vif.threshold;
                edge_count_q  <= sat_inc(cnt_q, edge_p3);
                cnt_q         <= '0;
                count_valid_q <= 1'b1;
            end else begin
                cnt_q         <= sat_inc(cnt_q, edge_p3);
                count_valid_q <= 1'b0;
            end
        end
    end

    assign vif.pixel_out   = pixel_p3;
    assign vif.de_out      = sync_p3.de;
    assign vif.h_sync_out  = sync_p3.h_sync;
    assign vif.v_sync_out  = sync_p3.v_sync;
    assign vif.edge_count  = edge_count_q;
    assign vif.count_valid = count_valid_q;

    // CbCr travels with the pixel but the binary output uses fixed chroma
    assign unused_bits = ^{cbcr_p2, vif.pixel_gy_in[15:0]};
endmodule

// File: tb/tb_sobel_edge_threshold.sv
// Directed bench for sobel_edge_threshold; a narrow counter makes saturation
// reachable within a short frame.
module tb_sobel_edge_threshold;
    localparam int CNT_W = 4;
    localparam logic [23:0] WHITE = 24'hFF8080;
    localparam logic [23:0] BLACK = 24'h008080;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    sobel_edge_threshold_if #(.CNT_W(CNT_W)) vif ();

    sobel_edge_threshold #(
        .THRESH_INIT (8'd64),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vif (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic signed [7:0] gx, input logic signed [7:0] gy,
                          input logic de, input logic hs, input logic vs);
        vif.pixel_gx_in = {gx, 16'h8080};
        vif.pixel_gy_in = {gy, 16'h1234};
        vif.de_in       = de;
        vif.h_sync_in   = hs;
        vif.v_sync_in   = vs;
    endtask

    task automatic idle(input int n);
        set_in(8'sd0, 8'sd0, 1'b0, 1'b0, 1'b0);
        repeat (n) tick();
    endtask

    // one pixel, then blanking; on return the pixel is at the output
    task automatic push_one(input logic signed [7:0] gx, input logic signed [7:0] gy, input logic de);
        set_in(gx, gy, de, 1'b0, 1'b0);
        tick();
        idle(2);
    endtask

    task automatic run_frame(input int n_edges);
        int e;
        e = 0;
        for (int line = 0; line < 4; line++) begin
            for (int p = 0; p < 83; p++) begin
                if (((line * 83 + p) % 16 == 7) && (e < n_edges)) begin
                    set_in(8'sd50, -8'sd20, 1'b1, 1'b0, 1'b0);
                    e++;
                end else begin
                    set_in(8'sd10, 8'sd5, 1'b1, 1'b0, 1'b0);
                end
                tick();
            end
            set_in(8'sd0, 8'sd0, 1'b0, 1'b1, 1'b0);
            tick();
            tick();
        end
        idle(4);
    endtask

    task automatic vsync_pulse(input int len, input logic edge_first,
                               output int strobes, output logic [CNT_W-1:0] cnt_seen);
        strobes  = 0;
        cnt_seen = '0;
        for (int c = 0; c < len + 8; c++) begin
            if (c == 0 && edge_first) set_in(8'sd50, -8'sd20, 1'b1, 1'b0, 1'b1);
            else if (c < len)         set_in(8'sd0, 8'sd0, 1'b0, 1'b0, 1'b1);
            else                      set_in(8'sd0, 8'sd0, 1'b0, 1'b0, 1'b0);
            tick();
            if (vif.count_valid === 1'b1) begin
                strobes++;
                cnt_seen = vif.edge_count;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vif.threshold = 8'd64;
        set_in(8'sd50, -8'sd20, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        n_checks++; if (vif.pixel_out !== 24'h0) begin n_fail++; $display("FAIL reset_pixel: got %h want 000000", vif.pixel_out); end
        n_checks++; if ({vif.de_out, vif.h_sync_out, vif.v_sync_out} !== 3'b000) begin n_fail++; $display("FAIL reset_sync: got %b want 000", {vif.de_out, vif.h_sync_out, vif.v_sync_out}); end
        n_checks++; if (vif.edge_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", vif.edge_count); end
        n_checks++; if (vif.count_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", vif.count_valid); end
        rst = 1'b0;
        set_in(8'sd0, 8'sd0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        n_checks++; if (vif.v_sync_out !== 1'b0) begin n_fail++; $display("FAIL vs_early: got %b want 0", vif.v_sync_out); end
        tick();
        n_checks++; if (vif.v_sync_out !== 1'b1) begin n_fail++; $display("FAIL vs_rise_after_reset: got %b want 1", vif.v_sync_out); end
        n_checks++; if (vif.count_valid !== 1'b0) begin n_fail++; $display("FAIL valid_on_rise: got %b want 0", vif.count_valid); end
        tick();
        n_checks++; if (vif.count_valid !== 1'b1) begin n_fail++; $display("FAIL valid_after_rise: got %b want 1", vif.count_valid); end
        n_checks++; if (vif.edge_count !== '0) begin n_fail++; $display("FAIL first_publish: got %0d want 0", vif.edge_count); end
        tick();
        n_checks++; if (vif.count_valid !== 1'b0) begin n_fail++; $display("FAIL valid_held_vs: got %b want 0", vif.count_valid); end
        idle(5);
    endtask

    task automatic test_classify();
        set_in(8'sd50, -8'sd20, 1'b1, 1'b1, 1'b0);
        tick();
        idle(1);
        n_checks++; if (vif.pixel_out !== 24'h0) begin n_fail++; $display("FAIL latency_early: got %h want 000000", vif.pixel_out); end
        tick();
        n_checks++; if (vif.pixel_out !== WHITE) begin n_fail++; $display("FAIL mag70_edge: got %h want %h", vif.pixel_out, WHITE); end
        n_checks++; if ({vif.de_out, vif.h_sync_out} !== 2'b11) begin n_fail++; $display("FAIL sync_align: got %b want 11", {vif.de_out, vif.h_sync_out}); end
        tick();
        n_checks++; if (vif.pixel_out !== 24'h0) begin n_fail++; $display("FAIL single_pixel: got %h want 000000", vif.pixel_out); end
        push_one(8'sd40, 8'sd24, 1'b1);
        n_checks++; if (vif.pixel_out !== BLACK) begin n_fail++; $display("FAIL mag64_equal: got %h want %h", vif.pixel_out, BLACK); end
        push_one(8'sd40, 8'sd24, 1'b0);
        n_checks++; if (vif.pixel_out !== 24'h0) begin n_fail++; $display("FAIL de_low: got %h want 000000", vif.pixel_out); end
        push_one(8'sh80, 8'sd0, 1'b1);
        n_checks++; if (vif.pixel_out !== WHITE) begin n_fail++; $display("FAIL abs_min_neg: got %h want %h", vif.pixel_out, WHITE); end
        push_one(-8'sd33, -8'sd32, 1'b1);
        n_checks++; if (vif.pixel_out !== WHITE) begin n_fail++; $display("FAIL mag65_edge: got %h want %h", vif.pixel_out, WHITE); end
        idle(2);
    endtask

    task automatic test_vsync_hold();
        int s;
        logic [CNT_W-1:0] c;
        vsync_pulse(4, 1'b0, s, c);
        n_checks++; if (s !== 1) begin n_fail++; $display("FAIL hold_strobes: got %0d want 1", s); end
        n_checks++; if (c !== 4'd3) begin n_fail++; $display("FAIL hold_count: got %0d want 3", c); end
    endtask

    task automatic test_frame();
        int s;
        logic [CNT_W-1:0] c;
        run_frame(10);
        vsync_pulse(1, 1'b0, s, c);
        n_checks++; if (s !== 1) begin n_fail++; $display("FAIL frame_strobes: got %0d want 1", s); end
        n_checks++; if (c !== 4'd10) begin n_fail++; $display("FAIL frame_count: got %0d want 10", c); end
        run_frame(3);
        vsync_pulse(1, 1'b1, s, c);
        n_checks++; if (c !== 4'd4) begin n_fail++; $display("FAIL edge_on_rise_closing: got %0d want 4", c); end
        vsync_pulse(1, 1'b0, s, c);
        n_checks++; if (s !== 1 || c !== 4'd0) begin n_fail++; $display("FAIL edge_on_rise_next: got %0d/%0d want 1/0", s, c); end
    endtask

    task automatic test_saturate();
        int s;
        logic [CNT_W-1:0] c;
        run_frame(21);
        vsync_pulse(1, 1'b0, s, c);
        n_checks++; if (c !== 4'd15) begin n_fail++; $display("FAIL saturate: got %0d want 15", c); end
        run_frame(1);
        vsync_pulse(1, 1'b0, s, c);
        n_checks++; if (c !== 4'd1) begin n_fail++; $display("FAIL after_saturate: got %0d want 1", c); end
    endtask

    task automatic test_thresh_255();
        int s;
        logic [CNT_W-1:0] c;
        vif.threshold = 8'd255;
        vsync_pulse(1, 1'b0, s, c);
        push_one(8'sh80, 8'sh80, 1'b1);
        n_checks++; if (vif.pixel_out !== WHITE) begin n_fail++; $display("FAIL mag256: got %h want %h", vif.pixel_out, WHITE); end
        push_one(8'sh80, -8'sd127, 1'b1);
        n_checks++; if (vif.pixel_out !== BLACK) begin n_fail++; $display("FAIL mag255_thr255: got %h want %h", vif.pixel_out, BLACK); end
        push_one(8'sd127, 8'sd127, 1'b1);
        n_checks++; if (vif.pixel_out !== BLACK) begin n_fail++; $display("FAIL mag254_thr255: got %h want %h", vif.pixel_out, BLACK); end
        vif.threshold = 8'd64;
        vsync_pulse(1, 1'b0, s, c);
        n_checks++; if (c !== 4'd1) begin n_fail++; $display("FAIL thr255_count: got %0d want 1", c); end
    endtask

    task automatic test_midframe_thresh();
        int s;
        logic [CNT_W-1:0] c;
        vif.threshold = 8'd200;
        push_one(8'sd100, 8'sd50, 1'b1);
        n_checks++; if (vif.pixel_out !== WHITE) begin n_fail++; $display("FAIL midframe_old_thr: got %h want %h", vif.pixel_out, WHITE); end
        vsync_pulse(1, 1'b0, s, c);
        push_one(8'sd100, 8'sd50, 1'b1);
        n_checks++; if (vif.pixel_out !== BLACK) begin n_fail++; $display("FAIL new_thr_150: got %h want %h", vif.pixel_out, BLACK); end
        push_one(8'sd120, 8'sd90, 1'b1);
        n_checks++; if (vif.pixel_out !== WHITE) begin n_fail++; $display("FAIL new_thr_210: got %h want %h", vif.pixel_out, WHITE); end
    endtask

    task automatic test_reset_midframe();
        int s;
        logic [CNT_W-1:0] c;
        for (int i = 0; i < 4; i++) push_one(8'sd120, 8'sd90, 1'b1);
        set_in(8'sd120, 8'sd90, 1'b1, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (vif.pixel_out !== 24'h0 || vif.de_out !== 1'b0) begin n_fail++; $display("FAIL midreset_out: got %h/%b want 000000/0", vif.pixel_out, vif.de_out); end
        n_checks++; if (vif.edge_count !== '0 || vif.count_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_count: got %0d/%b want 0/0", vif.edge_count, vif.count_valid); end
        idle(3);
        n_checks++; if (vif.pixel_out !== 24'h0) begin n_fail++; $display("FAIL inflight_dropped: got %h want 000000", vif.pixel_out); end
        push_one(8'sd50, -8'sd20, 1'b1);
        n_checks++; if (vif.pixel_out !== WHITE) begin n_fail++; $display("FAIL thr_init_after_reset: got %h want %h", vif.pixel_out, WHITE); end
        push_one(8'sd50, -8'sd20, 1'b1);
        vsync_pulse(2, 1'b0, s, c);
        n_checks++; if (s !== 1 || c !== 4'd2) begin n_fail++; $display("FAIL post_reset_publish: got %0d/%0d want 1/2", s, c); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_classify();
        test_vsync_hold();
        test_frame();
        test_saturate();
        test_thresh_255();
        test_midframe_thresh();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sobel_edge_threshold.md
SOBEL_EDGE_THRESHOLD -- requirements
Module: sobel_edge_threshold

Interface
REQ-001 Parameter THRESH_INIT, default 8'd64, threshold value loaded at reset.
REQ-002 Parameter CNT_W, default 21, width of the per-frame edge counter.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 pixel_gx_in  input  24  [23:16] horizontal gradient, signed two's complement; [15:0] CbCr.
REQ-006 pixel_gy_in  input  24  [23:16] vertical gradient, signed two's complement; [15:0] ignored.
REQ-007 de_in, h_sync_in, v_sync_in  input  1 each  timing, aligned with both gradient inputs.
REQ-008 threshold  input  8  requested edge threshold, unsigned.
REQ-009 pixel_out  output  24  binary edge pixel, YCbCr.
REQ-010 de_out, h_sync_out, v_sync_out  output  1 each  timing delayed to match pixel_out.
REQ-011 edge_count  output  CNT_W  edge-pixel count of the last completed frame.
REQ-012 count_valid  output  1  one-cycle strobe when edge_count updates.

Function
REQ-013 Latency SHALL be exactly 3 clk from any input to the corresponding pixel_out/de_out/h_sync_out/v_sync_out.
REQ-014 Stage 1 SHALL register |Gx| and |Gy| as 8-bit unsigned; -128 maps to 128 with no wrap.
REQ-015 Stage 2 SHALL register mag = |Gx| + |Gy| as 9-bit unsigned (range 0..256) and the CbCr delayed by 2 stages.
REQ-016 Stage 3 SHALL set edge = de_s2 AND (mag > thr_q), where thr_q is the active threshold register.
REQ-017 pixel_out SHALL be 24'hFF8080 when edge, 24'h008080 when de_s3=1 and not edge, 24'h000000 when de_s3=0.
REQ-018 thr_q SHALL load threshold only on the cycle where v_sync_out rises (0->1); mid-frame threshold changes SHALL NOT take effect.
REQ-019 Edge counter SHALL increment by 1 on every cycle where pixel_out is 24'hFF8080.
REQ-020 Edge counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-021 On v_sync_out rising: edge_count SHALL load the counter value, including any edge on that same cycle; count_valid SHALL be 1 on the following cycle only.
REQ-022 On v_sync_out rising, the counter SHALL restart at 0; an edge pixel on that cycle SHALL be counted in the closing frame only.
REQ-023 v_sync held high for multiple cycles SHALL produce only one count_valid strobe.
REQ-024 The first v_sync_out rise after reset SHALL publish whatever partial count has accumulated.

Reset
REQ-025 While rst=1 on a clock edge, all pipeline registers, pixel_out, de_out, h_sync_out, v_sync_out, edge_count, count_valid and the counter SHALL become 0, and thr_q SHALL become THRESH_INIT.
REQ-026 The v_sync edge detector history SHALL reset to 0, so v_sync_in=1 held through reset SHALL produce a rising edge 3 cycles after rst deasserts.
REQ-027 Reset asserted mid-frame SHALL discard in-flight pixels; outputs SHALL be 0 on the first cycle after the reset edge.

Structure
REQ-028 Shared video package SHALL hold YCBCR_WHITE (24'hFF8080), YCBCR_BLACK (24'h008080) and the gradient width constant (8).
REQ-029 One sub-module SHALL be used: sync_pipe, a resettable 3-deep shift register for {de, h_sync, v_sync}; all other logic SHALL be inline.

Verification
REQ-030 Gx=8'sd50, Gy=-8'sd20, de=1, thr_q=64 -> mag=70, pixel_out=24'hFF8080 exactly 3 cycles later.
REQ-031 Gx=8'sd40, Gy=8'sd24, de=1, thr_q=64 -> mag=64, not greater than threshold, pixel_out=24'h008080; same gradients with de=0 -> 24'h000000.
REQ-032 Gx=Gy=-128, threshold=255 loaded at v_sync_out rise -> mag=256, pixel_out=24'hFF8080, no overflow.
REQ-033 Frame of 83x4 active pixels, 10 gradients above threshold, then v_sync pulse -> edge_count=10 and count_valid high for exactly 1 cycle; the next frame's counter starts at 0.
REQ-034 threshold changed from 64 to 200 mid-frame -> classification unchanged until after the next v_sync_out rise, then uses 200.
REQ-035 rst asserted for 1 cycle mid-frame with 5 edges counted -> all outputs 0, thr_q=64; the next v_sync publishes only post-reset edges.
